tinyrv_fetch: RTL and testbench

TINYRV_FETCH -- requirements
Module: tinyrv_fetch

---
 rtl/tinyrv_pkg.sv | 15 +
 rtl/tinyrv_fetch.sv | 93 +++++++++
 tb/tb_tinyrv_fetch.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tinyrv_pkg.sv
// Shared types and constants for the tinyrv instruction fetch unit.
package tinyrv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/tinyrv_fetch.sv
// Single-outstanding instruction fetch: request, await response, hold for the core.
module tinyrv_fetch
  import tinyrv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = NOP_ENC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_err,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic            inst_valid,
  input  logic [XLEN-1:0] pc_next,
  input  logic            advance,
  output logic            fault
);

  fetch_state_t    state, state_d;
  logic [XLEN-1:0] fetch_pc, fetch_pc_d;
  logic [XLEN-1:0] inst_d, pc_d;
  logic            valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_d;
      fetch_pc   <= fetch_pc_d;
      pc         <= pc_d;
      inst       <= inst_d;
      inst_valid <= valid_d;
    end
  end

  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    pc_d       = pc;
    inst_d     = inst;
    valid_d    = inst_valid;
    case (state)
      IDLE:  state_d = FETCH;
      FETCH: if (mem_gnt) state_d = WAIT;
      WAIT: begin
        // error wins over data when both arrive together
        if (mem_rvalid) begin
          if (mem_err) begin
            state_d = FAULT;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
          end else begin
            state_d = HOLD;
            inst_d  = mem_rdata;
            pc_d    = fetch_pc;
            valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (advance) begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
          if (pc_next[1:0] != 2'b00) begin
            state_d = FAULT;
          end else begin
            state_d    = FETCH;
            fetch_pc_d = pc_next;
          end
        end
      end
      FAULT: begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req  = (state == FETCH);
  assign mem_addr = fetch_pc;
  assign fault    = (state == FAULT);

endmodule

// File: tb/tb_tinyrv_fetch.sv
// Directed vector table, async-reset sequences and randomized run against a behavioural model.
module tb_tinyrv_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [31:0] mem_addr, mem_rdata = '0;
  logic [31:0] inst, pc, pc_next = '0;
  logic        inst_valid, advance = 1'b0, fault;

  int checks = 0;
  int failures = 0;

  tinyrv_fetch dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .inst(inst), .pc(pc), .inst_valid(inst_valid),
    .pc_next(pc_next), .advance(advance), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s #%0d actual=%h expected=%h", nm, idx, act, exp);
    end
  endfunction

  typedef struct {
    logic rst, gnt, rv, err; logic [31:0] rdata; logic adv; logic [31:0] pcn;
    logic e_req; logic [31:0] e_addr; logic e_v; logic [31:0] e_inst, e_pc; logic e_f;
  } vec_t;

  function automatic vec_t mk(logic r, logic g, logic v, logic e, logic [31:0] d, logic a,
                              logic [31:0] n, logic xq, logic [31:0] xa, logic xv,
                              logic [31:0] xi, logic [31:0] xp, logic xf);
    vec_t t;
    t.rst = r; t.gnt = g; t.rv = v; t.err = e; t.rdata = d; t.adv = a; t.pcn = n;
    t.e_req = xq; t.e_addr = xa; t.e_v = xv; t.e_inst = xi; t.e_pc = xp; t.e_f = xf;
    return t;
  endfunction

  function automatic void chk_all(string nm, int idx, logic q, logic [31:0] a, logic v,
                                  logic [31:0] i, logic [31:0] p, logic f);
    chk({nm, ".mem_req"}, idx, mem_req, q);
    chk({nm, ".mem_addr"}, idx, mem_addr, a);
    chk({nm, ".inst_valid"}, idx, inst_valid, v);
    chk({nm, ".inst"}, idx, inst, i);
    chk({nm, ".pc"}, idx, pc, p);
    chk({nm, ".fault"}, idx, fault, f);
  endfunction

  // Behavioural model: flags describing what the fetcher is doing, updated per edge.
  logic        m_idle, m_req, m_wait, m_valid, m_fault;
  logic [31:0] m_fpc, m_inst, m_pc;

  task automatic model_step();
    if (rst) begin
      m_idle = 1; m_req = 0; m_wait = 0; m_valid = 0; m_fault = 0;
      m_fpc = 0; m_inst = NOP; m_pc = 0;
    end else if (m_fault) begin
      m_valid = 0; m_inst = NOP;
    end else if (m_idle) begin
      m_idle = 0; m_req = 1;
    end else if (m_req) begin
      if (mem_gnt) begin m_req = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (mem_rvalid) begin
        m_wait = 0;
        if (mem_err) begin m_fault = 1; m_valid = 0; m_inst = NOP; end
        else begin m_valid = 1; m_inst = mem_rdata; m_pc = m_fpc; end
      end
    end else if (m_valid && advance) begin
      m_valid = 0; m_inst = NOP;
      if (pc_next % 4 != 0) m_fault = 1;
      else begin m_fpc = pc_next; m_req = 1; end
    end
  endtask

  vec_t tbl[32];

  initial begin
    tbl[0]  = mk(1,0,0,0,0,0,0,                 0,0,0,NOP,0,0);
    tbl[1]  = mk(0,0,0,0,0,0,0,                 1,0,0,NOP,0,0);
    tbl[2]  = mk(0,1,0,0,0,0,0,                 0,0,0,NOP,0,0);
    tbl[3]  = mk(0,0,1,0,32'h0080_0093,0,0,     0,0,1,32'h0080_0093,0,0);
    tbl[4]  = mk(0,1,1,0,32'hDEAD_BEEF,0,0,     0,0,1,32'h0080_0093,0,0);
    tbl[5]  = mk(0,0,0,0,0,1,32'h4,             1,32'h4,0,NOP,0,0);
    tbl[6]  = mk(0,0,1,0,32'h1111_1111,1,32'h8, 1,32'h4,0,NOP,0,0);
    tbl[7]  = mk(0,0,0,0,0,0,0,                 1,32'h4,0,NOP,0,0);
    tbl[8]  = mk(0,0,0,0,0,0,0,                 1,32'h4,0,NOP,0,0);
    tbl[9]  = mk(0,0,0,0,0,0,0,                 1,32'h4,0,NOP,0,0);
    tbl[10] = mk(0,0,0,0,0,0,0,                 1,32'h4,0,NOP,0,0);
    tbl[11] = mk(0,1,0,0,0,0,0,                 0,32'h4,0,NOP,0,0);
    tbl[12] = mk(0,1,0,0,0,1,32'h10,            0,32'h4,0,NOP,0,0);
    tbl[13] = mk(0,0,1,0,32'h1234_5678,0,0,     0,32'h4,1,32'h1234_5678,32'h4,0);
    tbl[14] = mk(0,0,0,0,0,1,32'h6,             0,32'h4,0,NOP,32'h4,1);
    tbl[15] = mk(0,1,1,0,32'h5555_5555,1,0,     0,32'h4,0,NOP,32'h4,1);
    tbl[16] = mk(1,0,0,0,0,0,0,                 0,0,0,NOP,0,0);
    tbl[17] = mk(0,0,0,0,0,0,0,                 1,0,0,NOP,0,0);
    tbl[18] = mk(0,1,0,0,0,0,0,                 0,0,0,NOP,0,0);
    tbl[19] = mk(0,0,1,1,32'hFFFF_FFFF,0,0,     0,0,0,NOP,0,1);
    tbl[20] = mk(0,1,0,0,0,0,0,                 0,0,0,NOP,0,1);
    tbl[21] = mk(1,0,0,0,0,0,0,                 0,0,0,NOP,0,0);
    tbl[22] = mk(0,0,0,0,0,0,0,                 1,0,0,NOP,0,0);
    tbl[23] = mk(0,1,0,0,0,0,0,                 0,0,0,NOP,0,0);
    tbl[24] = mk(1,0,0,0,0,0,0,                 0,0,0,NOP,0,0);
    tbl[25] = mk(0,0,1,0,32'h0BAD_0BAD,0,0,     1,0,0,NOP,0,0);
    tbl[26] = mk(0,0,1,0,32'h0BAD_0BAD,0,0,     1,0,0,NOP,0,0);
    tbl[27] = mk(0,1,0,0,0,0,0,                 0,0,0,NOP,0,0);
    tbl[28] = mk(0,0,1,0,32'h0000_0513,0,0,     0,0,1,32'h0000_0513,0,0);
    tbl[29] = mk(0,0,0,0,0,1,32'hFFFF_FFFC,     1,32'hFFFF_FFFC,0,NOP,0,0);
    tbl[30] = mk(0,1,0,0,0,0,0,                 0,32'hFFFF_FFFC,0,NOP,0,0);
    tbl[31] = mk(0,0,1,0,32'hAAAA_5555,0,0,     0,32'hFFFF_FFFC,1,32'hAAAA_5555,32'hFFFF_FFFC,0);

    // Directed per-cycle vectors
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      rst = tbl[i].rst; mem_gnt = tbl[i].gnt; mem_rvalid = tbl[i].rv; mem_err = tbl[i].err;
      mem_rdata = tbl[i].rdata; advance = tbl[i].adv; pc_next = tbl[i].pcn;
      @(posedge clk); #1;
      chk_all("vec", i, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_v, tbl[i].e_inst,
              tbl[i].e_pc, tbl[i].e_f);
    end

    // Reset is asynchronous: clear a held instruction between edges
    mem_gnt = 0; mem_rvalid = 0; mem_err = 0; advance = 0;
    #2 rst = 1;
    #1 chk_all("async_hold", 0, 0, 0, 0, NOP, 0, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 chk_all("refetch", 0, 1, 0, 0, NOP, 0, 0);
    #2 rst = 1;
    #1 chk_all("async_fetch", 0, 0, 0, 0, NOP, 0, 0);

    // Randomized run against the model
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      model_step();
      #1 chk_all("rand", n, m_req, m_fpc, m_valid, m_inst, m_pc, m_fault);
      if (rst) rst = 0;
      else rst = ($urandom_range(0, 299) == 0) || (m_fault && $urandom_range(0, 7) == 0);
      mem_gnt    = ($urandom_range(0, 2) != 0);
      mem_rvalid = m_wait ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      mem_err    = mem_rvalid && ($urandom_range(0, 29) == 0);
      mem_rdata  = $urandom;
      advance    = ($urandom_range(0, 2) == 0);
      pc_next    = $urandom;
      if ($urandom_range(0, 19) != 0) pc_next = pc_next & ~32'h3;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
